// File: rtl/packet_register_bridge_if.sv
// ---------------------------------------------------------------------------
// packet_register_bridge_if
//   Byte stream of the UART packet link. Each beat carries one payload byte
//   plus the packet header, which stays constant for the whole packet.
//
//   Source       8  sending node address
//   Destination  8  receiving node address
//   Length       8  payload length in bytes
//   SoP          1  high with the first payload byte
//   EoP          1  high with the last payload byte
//   Data         8  payload byte
//   Valid        1  one beat per cycle while high
//
//   master : drives the stream
//   slave  : receives the stream
// ---------------------------------------------------------------------------
interface packet_register_bridge_if;
  logic [7:0] Source;
  logic [7:0] Destination;
  logic [7:0] Length;
  logic       SoP;
  logic       EoP;
  logic [7:0] Data;
  logic       Valid;

  modport master (
    output Source, Destination, Length, SoP, EoP, Data, Valid
  );

  modport slave (
    input Source, Destination, Length, SoP, EoP, Data, Valid
  );
endinterface

// File: rtl/packet_register_bridge.sv
// ---------------------------------------------------------------------------
// packet_register_bridge
//   Register-file endpoint between the UART packet receiver and transmitter.
//   Packets addressed to LOCAL_ADDR carry a command byte (00 read, 01 write)
//   and a start address. Writes fill consecutive registers; reads return N
//   consecutive registers as a reply packet to the sender.
//
//   Optional feature: define WRITE_ACK_EN to make every accepted write packet
//   return a one-byte reply holding the number of bytes written.
//
// Parameters
//   LOCAL_ADDR   node address (matched against Destination, used as Source)
//   REG_COUNT    number of 8-bit registers, power of two, 2..256
//
// Ports
//   ipClk        system clock
//   ipReset      asynchronous active-low reset
//   ipRxStream   received packet stream (no backpressure)
//   opTxStream   reply packet stream
//   ipTxReady    transmitter ready; a byte moves on Valid && ipTxReady
//   opRegisters  flat register bank, register i at [8*i+7:8*i]
//   opError      one-cycle pulse on a malformed or rejected packet
// ---------------------------------------------------------------------------
module packet_register_bridge #(
  parameter logic [7:0] LOCAL_ADDR = 8'h01,
  parameter int         REG_COUNT  = 16
) (
  input  logic                     ipClk,
  input  logic                     ipReset,
  packet_register_bridge_if.slave  ipRxStream,
  packet_register_bridge_if.master opTxStream,
  input  logic                     ipTxReady,
  output logic [8*REG_COUNT-1:0]   opRegisters,
  output logic                     opError
);

  localparam int ADDR_W = (REG_COUNT > 2) ? $clog2(REG_COUNT) : 1;

  localparam logic [7:0] CMD_READ  = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;

  typedef enum logic [2:0] {
    RX_CMD,
    RX_ADDR,
    RX_ARG,
    DISCARD,
    TX_REPLY
  } stateType;

  stateType state, stateNext;

  logic [7:0]        regBank [REG_COUNT];
  logic              isWrite;
  logic [ADDR_W-1:0] regAddr;
  logic              countSeen;
  logic [7:0]        replyDest;
  logic [7:0]        replyLen;
  logic [7:0]        txIdx;
  logic [7:0]        writeCount;
  logic              replyIsAck;

  // Control strobes from the next-state logic to the datapath.
  logic errorNext;
  logic loadCmd;
  logic loadAddr;
  logic doWrite;
  logic loadCount;
  logic startRead;
  logic startAck;
  logic txAdvance;

  logic rxStart;
  assign rxStart = ipRxStream.Valid && ipRxStream.SoP;

  // The payload is delimited by SoP/EoP, so the Length field is not needed.
  logic unusedRxLength;
  assign unusedRxLength = ^ipRxStream.Length;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) state <= RX_CMD;
    else          state <= stateNext;
  end

  // -------------------------------------------------------------------------
  // Next-state and control
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    stateNext = state;
    errorNext = 1'b0;
    loadCmd   = 1'b0;
    loadAddr  = 1'b0;
    doWrite   = 1'b0;
    loadCount = 1'b0;
    startRead = 1'b0;
    startAck  = 1'b0;
    txAdvance = 1'b0;

    case (state)
      TX_REPLY: begin
        // Incoming packets are dropped while replying; only a new SoP is
        // reported.
        if (rxStart) errorNext = 1'b1;
        if (ipTxReady) begin
          if (txIdx == replyLen - 8'd1) stateNext = RX_CMD;
          else                          txAdvance = 1'b1;
        end
      end

      default: begin
        if (rxStart) begin
          // A SoP always starts a fresh parse; interrupting an open packet
          // is itself an error.
          if (state != RX_CMD) errorNext = 1'b1;
          if (ipRxStream.Destination != LOCAL_ADDR) begin
            stateNext = ipRxStream.EoP ? RX_CMD : DISCARD;
          end else if (ipRxStream.Data != CMD_READ &&
                       ipRxStream.Data != CMD_WRITE) begin
            errorNext = 1'b1;
            stateNext = ipRxStream.EoP ? RX_CMD : DISCARD;
          end else if (ipRxStream.EoP) begin
            // Command byte alone: no address.
            errorNext = 1'b1;
            stateNext = RX_CMD;
          end else begin
            loadCmd   = 1'b1;
            stateNext = RX_ADDR;
          end
        end else if (ipRxStream.Valid) begin
          case (state)
            RX_ADDR: begin
              loadAddr = 1'b1;
              if (!ipRxStream.EoP) begin
                stateNext = RX_ARG;
              end else if (isWrite) begin
                // Write carrying no data: legal, nothing to store.
`ifdef WRITE_ACK_EN
                startAck  = 1'b1;
                stateNext = TX_REPLY;
`else
                stateNext = RX_CMD;
`endif
              end else begin
                // Read missing its count byte.
                errorNext = 1'b1;
                stateNext = RX_CMD;
              end
            end

            RX_ARG: begin
              if (isWrite) begin
                doWrite = 1'b1;
                if (ipRxStream.EoP) begin
`ifdef WRITE_ACK_EN
                  startAck  = 1'b1;
                  stateNext = TX_REPLY;
`else
                  stateNext = RX_CMD;
`endif
                end
              end else if (!countSeen) begin
                if (ipRxStream.Data == 8'd0) begin
                  errorNext = 1'b1;
                  stateNext = ipRxStream.EoP ? RX_CMD : DISCARD;
                end else begin
                  loadCount = 1'b1;
                  if (ipRxStream.EoP) begin
                    startRead = 1'b1;
                    stateNext = TX_REPLY;
                  end
                end
              end else if (ipRxStream.EoP) begin
                // Bytes after the count are ignored.
                startRead = 1'b1;
                stateNext = TX_REPLY;
              end
            end

            DISCARD: begin
              if (ipRxStream.EoP) stateNext = RX_CMD;
            end

            default: ;
          endcase
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      opError    <= 1'b0;
      isWrite    <= 1'b0;
      regAddr    <= '0;
      countSeen  <= 1'b0;
      replyDest  <= 8'd0;
      replyLen   <= 8'd0;
      txIdx      <= 8'd0;
      writeCount <= 8'd0;
      replyIsAck <= 1'b0;
      // NOTE: the register bank is architecturally visible and must read as
      // zero after reset, so it is reset like any other flop rather than
      // being left to a RAM.
      for (int i = 0; i < REG_COUNT; i++) regBank[i] <= 8'd0;
    end else begin
      opError <= errorNext;

      if (loadCmd) begin
        isWrite   <= ipRxStream.Data[0];
        replyDest <= ipRxStream.Source;
      end

      if (loadAddr) begin
        regAddr    <= ipRxStream.Data[ADDR_W-1:0];
        countSeen  <= 1'b0;
        writeCount <= 8'd0;
      end

      // Address arithmetic is ADDR_W bits wide, so it wraps at REG_COUNT.
      if (doWrite) begin
        regBank[regAddr] <= ipRxStream.Data;
        regAddr          <= regAddr + ADDR_W'(1);
        writeCount       <= writeCount + 8'd1;
      end

      if (loadCount) begin
        replyLen  <= ipRxStream.Data;
        countSeen <= 1'b1;
      end

      if (startRead) begin
        replyIsAck <= 1'b0;
        txIdx      <= 8'd0;
      end

      if (startAck) begin
        replyIsAck <= 1'b1;
        replyLen   <= 8'd1;
        txIdx      <= 8'd0;
      end

      if (txAdvance) txIdx <= txIdx + 8'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic              txActive;
  logic [ADDR_W-1:0] txRegIdx;

  assign txActive = (state == TX_REPLY);
  // Registers cannot change during a reply (Rx is ignored), so reading the
  // bank combinationally keeps Data stable while the transmitter stalls.
  assign txRegIdx = regAddr + txIdx[ADDR_W-1:0];

  assign opTxStream.Valid       = txActive;
  assign opTxStream.SoP         = txActive && (txIdx == 8'd0);
  assign opTxStream.EoP         = txActive && (txIdx == replyLen - 8'd1);
  assign opTxStream.Source      = txActive ? LOCAL_ADDR : 8'd0;
  assign opTxStream.Destination = txActive ? replyDest  : 8'd0;
  assign opTxStream.Length      = txActive ? replyLen   : 8'd0;
  assign opTxStream.Data        = !txActive  ? 8'd0 :
                                  replyIsAck ? writeCount :
                                               regBank[txRegIdx];

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
    assign opRegisters[8*g +: 8] = regBank[g];
  end

endmodule

// File: tb/tb_packet_register_bridge.sv
// ---------------------------------------------------------------------------
// tb_packet_register_bridge
//   Directed bench for packet_register_bridge (LOCAL_ADDR 01, REG_COUNT 16).
//   The stimulus process drives packets and keeps a packet-level model of the
//   register bank, expected error pulses and expected reply bytes; a single
//   negedge process compares the DUT against that model every cycle.
//   Define WRITE_ACK_EN for both bench and RTL to cover write acknowledges.
// ---------------------------------------------------------------------------
module tb_packet_register_bridge;

  localparam logic [7:0] LOCAL_ADDR = 8'h01;
  localparam int         REG_COUNT  = 16;

  logic                   ipClk = 1'b0;
  logic                   ipReset = 1'b0;
  logic                   ipTxReady = 1'b0;
  logic [8*REG_COUNT-1:0] opRegisters;
  logic                   opError;

  packet_register_bridge_if rxIf ();
  packet_register_bridge_if txIf ();

  packet_register_bridge #(
    .LOCAL_ADDR(LOCAL_ADDR),
    .REG_COUNT (REG_COUNT)
  ) dut (
    .ipClk      (ipClk),
    .ipReset    (ipReset),
    .ipRxStream (rxIf),
    .opTxStream (txIf),
    .ipTxReady  (ipTxReady),
    .opRegisters(opRegisters),
    .opError    (opError)
  );

  always #5 ipClk = ~ipClk;

  int compared   = 0;
  int mismatched = 0;

  // Model state: what the DUT outputs must be right now.
  logic [7:0] expRegs [REG_COUNT];
  bit         expErr;
  bit         expTxValid;
  bit         expSop;
  bit         expEop;
  logic [7:0] expTxData;
  logic [7:0] expTxDst;
  logic [7:0] expTxLen;

  // Effects of the byte currently on the Rx stream, visible after next edge.
  bit         pendErr;
  bit         pendWe;
  int         pendA;
  logic [7:0] pendD;

  bit         prevOpen;
  bit         checking = 1'b0;
  logic [7:0] replyQ [$];
  logic [7:0] replyDst;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] flatRegs();
    logic [127:0] r;
    for (int i = 0; i < REG_COUNT; i++) r[8*i +: 8] = expRegs[i];
    return r;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < REG_COUNT; i++) expRegs[i] = 8'h00;
    expErr     = 1'b0;
    expTxValid = 1'b0;
    pendErr    = 1'b0;
    pendWe     = 1'b0;
    prevOpen   = 1'b0;
  endtask

  // Advance one clock and retire the pending effects into the expectations.
  task automatic tick();
    @(posedge ipClk);
    #1;
    expErr  = pendErr;
    pendErr = 1'b0;
    if (pendWe) expRegs[pendA] = pendD;
    pendWe = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic setTx(input int idx);
    expTxValid = 1'b1;
    expTxData  = replyQ[idx];
    expSop     = (idx == 0);
    expEop     = (idx == replyQ.size() - 1);
    expTxDst   = replyDst;
    expTxLen   = 8'(replyQ.size());
  endtask

  // Send one packet of up to four bytes; the model decides each byte's effect
  // from the packet as a whole. Leaves the reply (if any) in replyQ with its
  // first byte expected on the outputs.
  task automatic sendPacket(input logic [7:0] src, input logic [7:0] dst,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input int len, input bit withEop);
    logic [7:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    replyQ.delete();
    for (int j = 0; j < len; j++) begin
      tick();
      rxIf.Valid       = 1'b1;
      rxIf.SoP         = (j == 0);
      rxIf.EoP         = withEop && (j == len - 1);
      rxIf.Data        = b[j];
      rxIf.Source      = src;
      rxIf.Destination = dst;
      rxIf.Length      = 8'(len);
      if (j == 0 && prevOpen) pendErr = 1'b1;
      if (dst == LOCAL_ADDR) begin
        if (b[0] > 8'h01) begin
          if (j == 0) pendErr = 1'b1;
        end else begin
          if (j == 0 && len == 1 && withEop) pendErr = 1'b1;
          if (b[0] == 8'h01 && j >= 2) begin
            pendWe = 1'b1;
            pendA  = (int'(b[1]) + j - 2) % REG_COUNT;
            pendD  = b[j];
          end
          if (b[0] == 8'h00) begin
            if (j == 1 && len == 2 && withEop) pendErr = 1'b1;
            if (j == 2 && b[2] == 8'h00) pendErr = 1'b1;
          end
        end
      end
    end
    prevOpen = !withEop;
    tick();
    rxIf.Valid = 1'b0;
    rxIf.SoP   = 1'b0;
    rxIf.EoP   = 1'b0;
    if (withEop && dst == LOCAL_ADDR && b[0] == 8'h00 && len >= 3 &&
        b[2] != 8'h00)
      for (int i = 0; i < int'(b[2]); i++)
        replyQ.push_back(expRegs[(int'(b[1]) + i) % REG_COUNT]);
`ifdef WRITE_ACK_EN
    if (withEop && dst == LOCAL_ADDR && b[0] == 8'h01 && len >= 2)
      replyQ.push_back(8'(len - 2));
`endif
    if (replyQ.size() > 0) begin
      replyDst = src;
      setTx(0);
    end
  endtask

  // Drain the expected reply, stalling `hold` cycles before each transfer.
  // With resetAt >= 0, reset is asserted while that byte is on the outputs.
  task automatic runReply(input int hold, input int resetAt);
    for (int idx = 0; idx < replyQ.size(); idx++) begin
      if (idx == resetAt) begin
        ipTxReady = 1'b0;
        ipReset   = 1'b0;
        resetModel();
        #1;
        check("async reset tx Valid", 128'(txIf.Valid), 128'd0);
        check("async reset registers", 128'(opRegisters), 128'd0);
        return;
      end
      ipTxReady = 1'b0;
      for (int h = 0; h < hold; h++) tick();
      ipTxReady = 1'b1;
      tick();
      if (idx + 1 < replyQ.size()) setTx(idx + 1);
      else                         expTxValid = 1'b0;
    end
    ipTxReady = 1'b0;
  endtask

  task automatic serviceReply();
    if (replyQ.size() > 0) runReply(0, -1);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge ipClk) begin
    if (checking) begin
      check("registers", 128'(opRegisters), flatRegs());
      check("opError", 128'(opError), 128'(expErr));
      check("tx Valid", 128'(txIf.Valid), 128'(expTxValid));
      if (expTxValid) begin
        check("tx Data", 128'(txIf.Data), 128'(expTxData));
        check("tx SoP", 128'(txIf.SoP), 128'(expSop));
        check("tx EoP", 128'(txIf.EoP), 128'(expEop));
        check("tx Source", 128'(txIf.Source), 128'(LOCAL_ADDR));
        check("tx Destination", 128'(txIf.Destination), 128'(expTxDst));
        check("tx Length", 128'(txIf.Length), 128'(expTxLen));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rxIf.Valid = 1'b0; rxIf.SoP = 1'b0; rxIf.EoP = 1'b0;
    rxIf.Data = 8'h00; rxIf.Source = 8'h00; rxIf.Destination = 8'h00;
    rxIf.Length = 8'h00;
    resetModel();
    repeat (3) @(posedge ipClk);
    #1;
    check("reset tx Valid", 128'(txIf.Valid), 128'd0);
    check("reset tx Data", 128'(txIf.Data), 128'd0);
    check("reset tx header",
          128'({txIf.Source, txIf.Destination, txIf.Length}), 128'd0);
    check("reset tx SoP/EoP", 128'({txIf.SoP, txIf.EoP}), 128'd0);
    check("reset registers", 128'(opRegisters), 128'd0);
    check("reset opError", 128'(opError), 128'd0);
    ipReset  = 1'b1;
    checking = 1'b1;
    idle(2);

    // Write AA BB to registers 3 and 4.
    sendPacket(8'h07, 8'h01, 8'h01, 8'h03, 8'hAA, 8'hBB, 4, 1'b1);
    check("write reg3 literal", 128'(opRegisters[31:24]), 128'hAA);
    check("write reg4 literal", 128'(opRegisters[39:32]), 128'hBB);
`ifdef WRITE_ACK_EN
    check("write ack data literal", 128'(txIf.Data), 128'h02);
`endif
    serviceReply();
    idle(2);

    // Read them back with a 5-cycle transmitter stall per byte.
    sendPacket(8'h07, 8'h01, 8'h00, 8'h03, 8'h02, 8'h00, 3, 1'b1);
    check("read first Data literal", 128'(txIf.Data), 128'hAA);
    check("read header literal",
          128'({txIf.Destination, txIf.Source, txIf.Length}), 128'h070102);
    check("read SoP/EoP literal", 128'({txIf.SoP, txIf.EoP}), 128'b10);
    runReply(5, -1);
    idle(2);

    // Address wrap: 15 -> 0.
    sendPacket(8'h09, 8'h01, 8'h01, 8'h0F, 8'h11, 8'h22, 4, 1'b1);
    check("wrap reg15 literal", 128'(opRegisters[127:120]), 128'h11);
    check("wrap reg0 literal", 128'(opRegisters[7:0]), 128'h22);
    serviceReply();
    idle(1);
    sendPacket(8'h09, 8'h01, 8'h00, 8'h0F, 8'h02, 8'h00, 3, 1'b1);
    check("wrap read first Data literal", 128'(txIf.Data), 128'h11);
    runReply(0, -1);
    idle(2);

    // Other node's packet, then an unknown command.
    sendPacket(8'h07, 8'h02, 8'h01, 8'h05, 8'h77, 8'h00, 3, 1'b1);
    idle(1);
    sendPacket(8'h07, 8'h01, 8'h05, 8'h00, 8'h12, 8'h00, 3, 1'b1);
    idle(2);

    // Read with N = 0: error the cycle after the count byte, no reply.
    sendPacket(8'h07, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 3, 1'b1);
    check("N=0 error literal", 128'(opError), 128'd1);
    check("N=0 no reply literal", 128'(txIf.Valid), 128'd0);
    idle(2);

    // Read abandoned in RX_ARG by a new write packet.
    sendPacket(8'h07, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 2, 1'b0);
    sendPacket(8'h07, 8'h01, 8'h01, 8'h08, 8'h5A, 8'h00, 3, 1'b1);
    check("restart write reg8 literal", 128'(opRegisters[71:64]), 128'h5A);
    serviceReply();
    idle(2);

    // Reset in the middle of a 3-byte reply.
    sendPacket(8'h07, 8'h01, 8'h00, 8'h03, 8'h03, 8'h00, 3, 1'b1);
    runReply(1, 1);
    idle(2);
    ipReset = 1'b1;
    idle(2);

    // Recovery and single-byte reply.
    sendPacket(8'h05, 8'h01, 8'h01, 8'h00, 8'hC3, 8'h00, 3, 1'b1);
    serviceReply();
    idle(1);
    sendPacket(8'h05, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 3, 1'b1);
    check("N=1 Data literal", 128'(txIf.Data), 128'hC3);
    check("N=1 SoP/EoP literal", 128'({txIf.SoP, txIf.EoP}), 128'b11);
    runReply(0, -1);
    idle(3);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
